// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps imem requests within buffer credit, and feeds
// {operation, pc_count} to op_decoder. FETCH_MISALIGN_CHK_EN adds fetch_misalign and a HALT state.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operation,
  output logic [31:0] pc_count
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    S_BOOT, S_RUN, S_DRAIN
`ifdef FETCH_MISALIGN_CHK_EN
    , S_HALT
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight, drop_cnt, drop_nxt, buf_count;
  logic [AW-1:0] buf_head, buf_tail, tag_head, tag_tail;
  fetch_ent_t    buf_mem [BUF_DEPTH];
  logic [31:0]   tag_mem [BUF_DEPTH];
  logic          req_fire, resp_live, pop, credit_ok;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = |redirect_pc[1:0];
`endif

  // inflight includes stale requests, so the buffer always has room for every response
  assign credit_ok = ({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_C;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_live = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;

  assign imem_req_addr = fetch_pc;
  assign operation     = buf_mem[buf_head].data;
  assign pc_count      = buf_mem[buf_head].pc;

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    drop_nxt       = drop_cnt;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN, S_DRAIN: begin
        imem_req_valid = credit_ok;
        out_valid      = buf_count != '0;
      end
      default: ;
    endcase
    if (imem_resp_valid && drop_cnt != '0) begin
      drop_nxt = drop_cnt - 1'b1;
      if (state == S_DRAIN && drop_cnt == CW'(1)) state_nxt = S_RUN;
    end
    // a response landing with the redirect is stale too, so it is not counted as pending
    if (redirect_valid) begin
      imem_req_valid = 1'b0;
      out_valid      = 1'b0;
      drop_nxt       = inflight - CW'(imem_resp_valid);
      state_nxt      = (drop_nxt != '0) ? S_DRAIN : S_RUN;
`ifdef FETCH_MISALIGN_CHK_EN
      if (misalign) state_nxt = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_BOOT;
      fetch_pc  <= RESET_PC;
      inflight  <= '0;
      drop_cnt  <= '0;
      buf_count <= '0;
      buf_head  <= '0;
      buf_tail  <= '0;
      tag_head  <= '0;
      tag_tail  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
      // tag FIFO keeps request order across redirects; stale responses pop their tag too
      if (req_fire) begin
        tag_mem[tag_tail] <= fetch_pc;
        tag_tail          <= tag_tail + 1'b1;
      end
      if (imem_resp_valid) tag_head <= tag_head + 1'b1;
      if (redirect_valid) begin
        fetch_pc  <= redirect_pc & ~32'h3;
        buf_count <= '0;
        buf_head  <= '0;
        buf_tail  <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_live) begin
          buf_mem[buf_tail] <= '{pc: tag_mem[tag_head], data: imem_resp_data};
          buf_tail          <= buf_tail + 1'b1;
        end
        if (pop) buf_head <= buf_head + 1'b1;
        buf_count <= buf_count + CW'(resp_live) - CW'(pop);
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_valid) fetch_misalign <= misalign;
`endif
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: an in-order imem model with programmable latency and an
// output capture queue checked against hand-computed pc/word sequences.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] operation;
  logic [31:0] pc_count;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
  int          f0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int nfire  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] cap_pc[$];
  logic [31:0] cap_op[$];

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation), .pc_count(pc_count)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // mid-cycle sampling of accepted requests and delivered instructions
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      nfire = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        nfire++;
      end
      if (out_valid && out_ready) begin
        cap_pc.push_back(pc_count);
        cap_op.push_back(operation);
      end
    end
  end

  // in-order response driver: a request accepted in cycle c answers in cycle c+lat
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // leaves the bench in the BOOT cycle right after reset release
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    cap_pc.delete();
    cap_op.delete();
    rst = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n);
    int k = 0;
    while (cap_pc.size() < n && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_count"}, 32'(cap_pc.size() >= n), 32'd1);
  endtask

  task automatic chk_stream(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < cap_pc.size()) begin
        chk({tag, "_pc"}, cap_pc[i], base + 32'(4 * i));
        chk({tag, "_op"}, cap_op[i], word(base + 32'(4 * i)));
      end
    end
  endtask

  initial begin
    // reset values
    step(3);
    mid();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",  imem_req_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_operation", operation, 32'h0);
    chk("rst_pc_count",  pc_count, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

    // boot cycle, then first fetch at RESET_PC, streaming with latency 1
    step();
    cap_pc.delete();
    cap_op.delete();
    rst = 1'b0;
    mid();
    chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    mid();
    chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c1_req_addr",  imem_req_addr, 32'h0);
    wait_outs("seq", 6);
    chk_stream("seq", 32'h0, 6);

    // decoder stalled: credit caps outstanding+buffered at 2
    out_ready = 1'b0;
    do_reset();
    step(12);
    mid();
    chk("bp_fires",     32'(nfire), 32'd2);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pc",   pc_count, 32'h0);
    step();
    out_ready = 1'b1;
    wait_outs("bp", 6);
    chk_stream("bp", 32'h0, 6);

    // latency 3, two requests outstanding, redirect to 0x100
    lat = 3;
    do_reset();
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    mid();
    chk("drn_pending",   32'(pend.size()), 32'd2);
    chk("drn_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drn_out_valid", 32'(out_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    mid();
    chk("drn_no_credit", 32'(imem_req_valid), 32'd0);
    wait_outs("drn", 2);
    chk_stream("drn", 32'h100, 2);

    // redirect coincides with a response while one more is in flight
    lat = 2;
    do_reset();
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    mid();
    chk("same_req_valid", 32'(imem_req_valid), 32'd1);
    chk("same_req_addr",  imem_req_addr, 32'h200);
    wait_outs("same", 2);
    chk_stream("same", 32'h200, 2);

    // reset while draining with a request on the bus
    do_reset();
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    rst = 1'b1;
    step();
    mid();
    chk("rdrn_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rdrn_req_addr",  imem_req_addr, 32'h0);
    chk("rdrn_out_valid", 32'(out_valid), 32'd0);
    chk("rdrn_operation", operation, 32'h0);
    chk("rdrn_pc_count",  pc_count, 32'h0);
    step();
    cap_pc.delete();
    cap_op.delete();
    rst = 1'b0;
    step();
    mid();
    chk("rdrn_boot_req",  32'(imem_req_valid), 32'd1);
    chk("rdrn_boot_addr", imem_req_addr, 32'h0);
    wait_outs("rdrn", 2);
    chk_stream("rdrn", 32'h0, 2);

`ifdef FETCH_MISALIGN_CHK_EN
    // misaligned redirect halts fetch until an aligned redirect
    lat = 1;
    do_reset();
    wait_outs("mis_pre", 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    mid();
    chk("mis_flag",      32'(fetch_misalign), 32'd1);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mis_out_valid", 32'(out_valid), 32'd0);
    f0 = nfire;
    step(6);
    mid();
    chk("mis_no_fire",    32'(nfire), 32'(f0));
    chk("mis_hold_out",   32'(out_valid), 32'd0);
    chk("mis_hold_flag",  32'(fetch_misalign), 32'd1);
    step();
    cap_pc.delete();
    cap_op.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    mid();
    chk("mis_clear", 32'(fetch_misalign), 32'd0);
    wait_outs("mis", 2);
    chk_stream("mis", 32'h200, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
